// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like port arbiter: master IDs,
// request bundle layout and the default outstanding-FIFO depth.
package sram_like_arbiter_pkg;

    // Master ID encoding, also the value stored in the outstanding FIFO
    typedef enum logic {
        MID_INST = 1'b0,
        MID_DATA = 1'b1
    } mid_e;

    // Request bundle: wr, size, wstrb, addr, wdata
    localparam int unsigned REQ_W = 71;

    // Default number of address-accepted, data-pending transactions
    localparam int unsigned OST_DEPTH_DEF = 4;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// SRAM-like request/response bundle. The master modport issues requests,
// the slave modport accepts them and returns addr_ok/data_ok/rdata.
interface sram_like_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter_ost_id_fifo.sv
// In-order FIFO of master IDs for transactions whose address has been
// accepted but whose data response has not yet returned.
module ost_id_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 1,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Store the issuing ID at the write pointer
    // NOTE: storage has no reset; count gates every read, so stale slots are never seen.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Advance pointers (power-of-2 depth wraps naturally) and track occupancy
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master arbiter for one SRAM-like memory port. Grants are held until
// the address handshake completes; data_ok is routed back to the issuing
// master through an in-order outstanding-ID FIFO.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration
// between simultaneous requesters; otherwise m1 (data) has fixed priority.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned OST_DEPTH = OST_DEPTH_DEF,
    parameter int unsigned OST_PTR_W = $clog2(OST_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    sram_like_if.slave  m0,
    sram_like_if.slave  m1,
    sram_like_if.master s,
    output logic        ost_full,
    output logic        err_spurious
);

    logic             lock_valid;
    mid_e             lock_id;
    mid_e             grant;
    logic             gnt_req;
    logic             handshake;
    logic [REQ_W-1:0] m0_bundle;
    logic [REQ_W-1:0] m1_bundle;
    sram_req_t        s_fields;
    logic             fifo_pop;
    logic [0:0]       fifo_head;
    logic [OST_PTR_W:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    mid_e             head_id;

`ifdef ARB_ROUND_ROBIN_EN
    mid_e             rr_last;
`endif

    assign m0_bundle = {m0.wr, m0.size, m0.wstrb, m0.addr, m0.wdata};
    assign m1_bundle = {m1.wr, m1.size, m1.wstrb, m1.addr, m1.wdata};

    // Pick the master that owns the shared port this cycle
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant = MID_INST;
        if (lock_valid) begin
            grant = lock_id;
`ifdef ARB_ROUND_ROBIN_EN
        end else if (m0.req && m1.req) begin
            grant = (rr_last == MID_DATA) ? MID_INST : MID_DATA;
`endif
        end else if (m1.req) begin
            grant = MID_DATA;
        end
        gnt_req = (grant == MID_DATA) ? m1.req : m0.req;
    end

    // Forward the granted master's request fields; idle bus reads as zero
    always_comb begin
        s_fields = '0;
        if (gnt_req) begin
            s_fields = (grant == MID_DATA) ? m1_bundle : m0_bundle;
        end
    end

    assign s.req     = gnt_req && !ost_full;
    assign s.wr      = s_fields.wr;
    assign s.size    = s_fields.size;
    assign s.wstrb   = s_fields.wstrb;
    assign s.addr    = s_fields.addr;
    assign s.wdata   = s_fields.wdata;

    assign handshake = s.req && s.addr_ok;
    assign m0.addr_ok = handshake && (grant == MID_INST);
    assign m1.addr_ok = handshake && (grant == MID_DATA);

    // Responses return in issue order; the FIFO head names their owner
    assign fifo_pop   = s.data_ok && !fifo_empty;
    assign head_id    = mid_e'(fifo_head);
    assign m0.data_ok = fifo_pop && (head_id == MID_INST);
    assign m1.data_ok = fifo_pop && (head_id == MID_DATA);
    assign m0.rdata   = s.rdata;
    assign m1.rdata   = s.rdata;

    // Full is taken from the registered count, so a same-cycle pop frees nothing
    assign ost_full = fifo_full;

    ost_id_fifo #(
        .DEPTH (OST_DEPTH),
        .WIDTH (1)
    ) u_ost_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (handshake),
        .push_data (grant),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Hold the grant on a master whose request is waiting for addr_ok
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_valid <= 1'b0;
            lock_id    <= MID_INST;
        end else if (s.req) begin
            lock_valid <= !s.addr_ok;
            if (!s.addr_ok) begin
                lock_id <= grant;
            end
        end
    end

    // Flag a response that arrives with nothing outstanding; sticky until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_spurious <= 1'b0;
        end else if (s.data_ok && (fifo_count == '0)) begin
            err_spurious <= 1'b1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember who last completed an address handshake for round-robin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last <= MID_DATA;
        end else if (handshake) begin
            rr_last <= grant;
        end
    end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter. Stimulus pushes the expected
// address handshakes and data responses into queues; a negedge monitor
// pops and compares whenever the DUT asserts addr_ok or data_ok.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    typedef struct {
        logic        id;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic reset;
    logic ost_full;
    logic err_spurious;

    sram_like_if m0_if ();
    sram_like_if m1_if ();
    sram_like_if s_if ();

    exp_t addr_q[$];
    exp_t data_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;
    logic first_id;

    sram_like_arbiter #(.OST_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .m0           (m0_if),
        .m1           (m1_if),
        .s            (s_if),
        .ost_full     (ost_full),
        .err_spurious (err_spurious)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic req, input logic [31:0] addr);
        m0_if.req   = req;
        m0_if.wr    = 1'b0;
        m0_if.size  = req ? 2'd2 : 2'd0;
        m0_if.wstrb = 4'h0;
        m0_if.addr  = addr;
        m0_if.wdata = 32'h0;
    endtask

    task automatic drive_m1(input logic req, input logic [31:0] addr);
        m1_if.req   = req;
        m1_if.wr    = req;
        m1_if.size  = req ? 2'd2 : 2'd0;
        m1_if.wstrb = req ? 4'hF : 4'h0;
        m1_if.addr  = addr;
        m1_if.wdata = req ? (addr ^ 32'h5A5A_0000) : 32'h0;
    endtask

    task automatic s_drive(input logic addr_ok, input logic data_ok, input logic [31:0] rdata);
        s_if.addr_ok = addr_ok;
        s_if.data_ok = data_ok;
        s_if.rdata   = rdata;
    endtask

    task automatic idle();
        drive_m0(1'b0, 32'h0);
        drive_m1(1'b0, 32'h0);
        s_drive(1'b0, 1'b0, 32'h0);
    endtask

    // Scoreboard monitor: compare every handshake the DUT presents
    always @(negedge clk) begin
        if (!reset) begin
            if (m0_if.addr_ok || m1_if.addr_ok) begin
                if (addr_q.size() == 0 || (m0_if.addr_ok && m1_if.addr_ok)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL addr_ok_unexpected: m0_addr_ok=%0b m1_addr_ok=%0b, expected none queued=%0d",
                             m0_if.addr_ok, m1_if.addr_ok, addr_q.size());
                end else begin
                    mon_e = addr_q.pop_front();
                    check("addr_ok_id", {31'd0, m1_if.addr_ok}, {31'd0, mon_e.id});
                    check("s_addr_at_addr_ok", s_if.addr, mon_e.val);
                end
            end
            if (m0_if.data_ok || m1_if.data_ok) begin
                if (data_q.size() == 0 || (m0_if.data_ok && m1_if.data_ok)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL data_ok_unexpected: m0_data_ok=%0b m1_data_ok=%0b, expected none queued=%0d",
                             m0_if.data_ok, m1_if.data_ok, data_q.size());
                end else begin
                    mon_e = data_q.pop_front();
                    check("data_ok_id", {31'd0, m1_if.data_ok}, {31'd0, mon_e.id});
                    check("rdata", m1_if.data_ok ? m1_if.rdata : m0_if.rdata, mon_e.val);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle();

        // Reset state
        @(negedge clk);
        check("rst_s_req", {31'd0, s_if.req}, 32'd0);
        check("rst_s_addr", s_if.addr, 32'd0);
        check("rst_ost_full", {31'd0, ost_full}, 32'd0);
        check("rst_err_spurious", {31'd0, err_spurious}, 32'd0);
        step();
        reset = 1'b0;

        // Simultaneous requests, right after reset
`ifdef ARB_ROUND_ROBIN_EN
        first_id = 1'b0;
`else
        first_id = 1'b1;
`endif
        step();
        drive_m0(1'b1, 32'h1C00_0010);
        drive_m1(1'b1, 32'h8000_1000);
        s_drive(1'b1, 1'b0, 32'h0);
        addr_q.push_back('{first_id, first_id ? 32'h8000_1000 : 32'h1C00_0010});
        step();
        if (first_id) drive_m1(1'b0, 32'h0);
        else          drive_m0(1'b0, 32'h0);
        addr_q.push_back('{!first_id, first_id ? 32'h1C00_0010 : 32'h8000_1000});
        step();
        idle();
        step();
        s_drive(1'b0, 1'b1, 32'hA000_0001);
        data_q.push_back('{first_id, 32'hA000_0001});
        step();
        s_drive(1'b0, 1'b1, 32'hA000_0002);
        data_q.push_back('{!first_id, 32'hA000_0002});
        step();
        idle();

        // Single m0 read, zero-latency addr_ok, data two cycles later
        step();
        drive_m0(1'b1, 32'h1C00_0000);
        s_drive(1'b1, 1'b0, 32'h0);
        addr_q.push_back('{1'b0, 32'h1C00_0000});
        step();
        idle();
        @(negedge clk);
        check("idle_s_req", {31'd0, s_if.req}, 32'd0);
        step();
        s_drive(1'b0, 1'b1, 32'h0280_0C00);
        data_q.push_back('{1'b0, 32'h0280_0C00});
        step();
        idle();

        // Lock: m0 held for 3 cycles while m1 also requests
        step();
        drive_m0(1'b1, 32'h1C00_0100);
        s_drive(1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) drive_m1(1'b1, 32'h8000_2000);
            if (c == 3) begin
                s_drive(1'b1, 1'b0, 32'h0);
                addr_q.push_back('{1'b0, 32'h1C00_0100});
            end
            @(negedge clk);
            check($sformatf("lock_s_addr_c%0d", c), s_if.addr, 32'h1C00_0100);
            check($sformatf("lock_s_req_c%0d", c), {31'd0, s_if.req}, 32'd1);
            step();
        end
        drive_m0(1'b0, 32'h0);
        addr_q.push_back('{1'b1, 32'h8000_2000});
        @(negedge clk);
        check("lock_release_s_addr", s_if.addr, 32'h8000_2000);
        step();
        idle();
        step();
        s_drive(1'b0, 1'b1, 32'hB000_0000);
        data_q.push_back('{1'b0, 32'hB000_0000});
        step();
        s_drive(1'b0, 1'b1, 32'hB000_0001);
        data_q.push_back('{1'b1, 32'hB000_0001});
        step();
        idle();

        // Fill the outstanding FIFO, then block and release
        for (int i = 0; i < 4; i++) begin
            step();
            idle();
            s_drive(1'b1, 1'b0, 32'h0);
            if (i % 2 == 0) drive_m0(1'b1, 32'h1C00_1000 + 32'(i * 4));
            else            drive_m1(1'b1, 32'h8000_3000 + 32'(i * 4));
            addr_q.push_back('{1'((i % 2)), (i % 2 == 0) ? 32'h1C00_1000 + 32'(i * 4)
                                                          : 32'h8000_3000 + 32'(i * 4)});
        end
        step();
        drive_m0(1'b0, 32'h0);
        drive_m1(1'b1, 32'h8000_4000);
        s_drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("full_ost_full", {31'd0, ost_full}, 32'd1);
        check("full_s_req", {31'd0, s_if.req}, 32'd0);
        check("full_m1_addr_ok", {31'd0, m1_if.addr_ok}, 32'd0);
        step();
        s_drive(1'b1, 1'b1, 32'hC000_0000);
        data_q.push_back('{1'b0, 32'hC000_0000});
        @(negedge clk);
        check("full_pop_ost_full", {31'd0, ost_full}, 32'd1);
        check("full_pop_s_req", {31'd0, s_if.req}, 32'd0);
        step();
        s_drive(1'b1, 1'b0, 32'h0);
        addr_q.push_back('{1'b1, 32'h8000_4000});
        @(negedge clk);
        check("after_pop_ost_full", {31'd0, ost_full}, 32'd0);
        check("after_pop_s_req", {31'd0, s_if.req}, 32'd1);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            s_drive(1'b0, 1'b1, 32'hC000_0001 + 32'(i));
            data_q.push_back('{(i == 1) ? 1'b0 : 1'b1, 32'hC000_0001 + 32'(i)});
            step();
        end
        idle();

        // Spurious response, stickiness, and clearing by reset
        step();
        s_drive(1'b0, 1'b1, 32'hBAD0_0001);
        @(negedge clk);
        check("spur_m0_data_ok", {31'd0, m0_if.data_ok}, 32'd0);
        check("spur_m1_data_ok", {31'd0, m1_if.data_ok}, 32'd0);
        step();
        idle();
        @(negedge clk);
        check("spur_err_set", {31'd0, err_spurious}, 32'd1);
        step();
        drive_m0(1'b1, 32'h1C00_2000);
        s_drive(1'b1, 1'b0, 32'h0);
        addr_q.push_back('{1'b0, 32'h1C00_2000});
        step();
        idle();
        @(negedge clk);
        check("spur_err_sticky", {31'd0, err_spurious}, 32'd1);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("reset_clears_err", {31'd0, err_spurious}, 32'd0);
        step();
        reset = 1'b0;
        step();
        s_drive(1'b0, 1'b1, 32'hBAD0_0002);
        @(negedge clk);
        check("post_reset_m0_data_ok", {31'd0, m0_if.data_ok}, 32'd0);
        step();
        idle();
        @(negedge clk);
        check("post_reset_err_set", {31'd0, err_spurious}, 32'd1);

        step();
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("data_q_drained", 32'(data_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
